// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the asynchronous FIFO.
package fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits beyond the pointer width are zero, so they never disturb the lower result.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module ptr_sync #(
  parameter int width       = 4,
  parameter int sync_stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] stage_q [sync_stages];

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q[0] <= '0;
    end else begin
      stage_q[0] <= d_i;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < sync_stages; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          stage_q[gi] <= '0;
        end else begin
          stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  assign q_o = stage_q[sync_stages-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status controller: owns the write pointer, synchronises the read
// pointer and registers full / almost_full / fill level / sticky overflow.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int depth       = 8,
  parameter int adr_width   = $clog2(depth),
  parameter int sync_stages = 2,
  parameter int af_thresh   = depth - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_en,
  input  logic [adr_width:0]   read_ptr_gray,
  output logic                 mem_write_en,
  output logic [adr_width-1:0] write_adr,
  output logic [adr_width:0]   write_ptr_gray,
  output logic                 FIFO_full,
  output logic                 almost_full,
  output logic [adr_width:0]   fill_level,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  localparam int PTR_W = adr_width + 1;
  localparam logic [PTR_W-1:0] AF_TH = PTR_W'(af_thresh);
  localparam logic [PTR_W-1:0] ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] rq, rbin;
  logic             full_q, full_d;
  logic             af_q, af_d;
  logic             ovf_q, ovf_d;
  logic             accept;

  ptr_sync #(
    .width      (PTR_W),
    .sync_stages(sync_stages)
  ) u_rptr_sync (
    .clk(clk),
    .rst(rst),
    .d_i(read_ptr_gray),
    .q_o(rq)
  );

  assign rbin   = PTR_W'(gray2bin(32'(rq)));
  assign accept = write_en & ~full_q;

  // Flags are recomputed every cycle so a read-pointer advance clears full without a write.
  always_comb begin
    wbin_d  = accept ? wbin_q + ONE : wbin_q;
    wgray_d = PTR_W'(bin2gray(32'(wbin_d)));
    full_d  = (wbin_d[adr_width-1:0] == rbin[adr_width-1:0]) &&
              (wbin_d[adr_width] != rbin[adr_width]);
    fill_d  = wbin_d - rbin;
    af_d    = (fill_d >= AF_TH);
    ovf_d   = (write_en & full_q) | (ovf_q & ~overflow_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      fill_q  <= fill_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_write_en   = accept;
  assign write_adr      = wbin_q[adr_width-1:0];
  assign write_ptr_gray = wgray_q;
  assign FIFO_full      = full_q;
  assign almost_full    = af_q;
  assign fill_level     = fill_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl (depth 8, two sync stages, almost_full at 6).
module tb_wptr_full_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write_en = 1'b0;
  logic [3:0] read_ptr_gray = '0;
  logic       overflow_clr = 1'b0;
  logic       mem_write_en;
  logic [2:0] write_adr;
  logic [3:0] write_ptr_gray;
  logic       FIFO_full;
  logic       almost_full;
  logic [3:0] fill_level;
  logic       overflow;

  wptr_full_ctrl #(.depth(8), .sync_stages(2), .af_thresh(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .write_en      (write_en),
    .read_ptr_gray (read_ptr_gray),
    .mem_write_en  (mem_write_en),
    .write_adr     (write_adr),
    .write_ptr_gray(write_ptr_gray),
    .FIFO_full     (FIFO_full),
    .almost_full   (almost_full),
    .fill_level    (fill_level),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mwe;
    logic [2:0] adr;
    logic [3:0] gray;
    logic       full;
    logic       af;
    logic [3:0] fill;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_a;
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model: counts of writes accepted and reads done, plus the read pointer
  // as seen through the two-cycle synchroniser delay.
  int   wtot = 0;
  int   rc = 0;
  int   rpipe[2] = '{0, 0};
  bit   m_full = 0;
  bit   m_ovf = 0;

  function automatic logic [3:0] to_gray(input int v);
    logic [3:0] b;
    b = 4'(v % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic step(input bit r, input bit we, input bit clr);
    int   rvis;
    int   fill;
    exp_t e;
    @(negedge clk);
    rst = r;
    write_en = we;
    overflow_clr = clr;
    read_ptr_gray = to_gray(rc);
    if (r) begin
      wtot = 0;
      rpipe = '{0, 0};
      m_full = 0;
      m_ovf = 0;
      fill = 0;
    end else begin
      rvis = rpipe[0];
      rpipe[0] = rpipe[1];
      rpipe[1] = rc % 16;
      if (we && m_full) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (we && !m_full) wtot++;
      fill = ((wtot % 16) - rvis + 16) % 16;
      m_full = (fill == 8);
    end
    e.mwe  = we && !m_full;
    e.adr  = 3'(wtot % 8);
    e.gray = to_gray(wtot);
    e.full = m_full;
    e.af   = (fill >= 6);
    e.fill = 4'(fill);
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge the DUT presents a fresh status word; compare it to the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{mem_write_en, write_adr, write_ptr_gray, FIFO_full, almost_full, fill_level, overflow};
      n_checks++;
      if (mon_a == mon_e) n_pass++;
      else $display("FAIL status @%0t: got mwe=%0b adr=%0d gray=%h full=%0b af=%0b fill=%0d ovf=%0b expected mwe=%0b adr=%0d gray=%h full=%0b af=%0b fill=%0d ovf=%0b",
                    $time, mon_a.mwe, mon_a.adr, mon_a.gray, mon_a.full, mon_a.af, mon_a.fill, mon_a.ovf,
                    mon_e.mwe, mon_e.adr, mon_e.gray, mon_e.full, mon_e.af, mon_e.fill, mon_e.ovf);
    end
  end

  initial begin
    // Reset and a single write
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    after_edge();
    check("single_write_adr", int'(write_adr), 1);
    check("single_write_gray", int'(write_ptr_gray), 1);
    check("single_write_fill", int'(fill_level), 1);

    // Fill from empty
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    after_edge();
    check("fill_full", int'(FIFO_full), 1);
    check("fill_gray", int'(write_ptr_gray), 4'hC);
    check("fill_level8", int'(fill_level), 8);

    // Overflow, set-wins, clear
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 0, 1);
    step(0, 0, 0);

    // Drain sync: one read, full drops exactly three edges later
    rc = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    after_edge();
    check("drain_full_early", int'(FIFO_full), 1);
    step(0, 0, 0);
    after_edge();
    check("drain_full_late", int'(FIFO_full), 0);
    check("drain_fill7", int'(fill_level), 7);
    step(0, 0, 0);

    // Wrap: reader trails the writer
    for (int i = 0; i < 20; i++) begin
      if (wtot - rc > 3) rc++;
      step(0, 1, 0);
    end
    for (int i = 0; i < 6; i++) begin
      if (rc < wtot) rc++;
      step(0, 0, 0);
    end

    // Reset mid-operation at fill level 5
    rc = 0;
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    after_edge();
    check("midop_fill5", int'(fill_level), 5);
    step(1, 1, 0);
    after_edge();
    check("midop_rst_fill", int'(fill_level), 0);
    check("midop_rst_adr", int'(write_adr), 0);
    step(0, 1, 0);
    after_edge();
    check("midop_resume_adr", int'(write_adr), 1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      bit r;
      r = ($urandom_range(0, 99) == 0);
      if (r) rc = 0;
      else if ($urandom_range(0, 1) == 1 && rc < wtot) rc++;
      step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end

    step(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
